// File: rtl/qspi_emu_pkg.sv
// Shared types and constants for the quad-SPI RAM emulator.
package qspi_emu_pkg;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE
  } state_e;

  localparam logic [7:0] CMD_QREAD    = 8'hEB;
  localparam logic [7:0] CMD_QWRITE   = 8'h38;
  localparam int         CMD_NIBBLES  = 2;
  localparam int         ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with single-clk rise/fall pulses.
module qspi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;
  assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/qspi_ram_emu.sv
// Quad-SPI flash/PSRAM emulator in front of an 8-bit BRAM (one-clk read latency).
// Define QSPI_EMU_WRITE_EN to accept the 0x38 quad-write command.
module qspi_ram_emu
  import qspi_emu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic [3:0]            spi_d_in,
  output logic [3:0]            spi_d_out,
  output logic                  spi_d_oe,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [7:0]            bram_din,
  input  logic [7:0]            bram_dout,
  output logic                  bram_wen,
  output logic                  bram_ren
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_lvl, cs_fall, cs_rise_unused;

  qspi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .async_i(spi_clk),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  qspi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .async_i(spi_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise_unused), .fall_o(cs_fall)
  );

  logic [1:0][3:0] d_sync_q;
  logic [3:0]      sd;
  assign sd = d_sync_q[1];

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [3:0]            cmd_hi_q, cmd_hi_d;
  logic [23:0]           addr_q, addr_d;
  logic                  nib_hi_q, nib_hi_d;
  logic [7:0]            cur_q, cur_d, nxt_q, nxt_d;
  logic                  ren_dly_q;
  logic                  armed_q, armed_d;
  logic [1:0]            settle_q, settle_d;
  logic [3:0]            dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic                  ren_q, ren_d;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^addr_q[23:20];

`ifdef QSPI_EMU_WRITE_EN
  logic       is_wr_q, is_wr_d;
  logic [3:0] wr_hi_q, wr_hi_d;
  logic [7:0] din_q, din_d;
  logic       wen_q, wen_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_hi_d = cmd_hi_q;
    addr_d   = addr_q;
    nib_hi_d = nib_hi_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    baddr_d  = baddr_q;
    ren_d    = 1'b0;
    // A cs_n fall is only trusted once the synchronisers have flushed and
    // cs_n has been seen high; this blocks a start straight out of reset.
    settle_d = settle_q[1] ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | (cs_lvl & settle_q[1]);
`ifdef QSPI_EMU_WRITE_EN
    is_wr_d  = is_wr_q;
    wr_hi_d  = wr_hi_q;
    din_d    = din_q;
    wen_d    = 1'b0;
    if (wen_q) baddr_d = baddr_q + 1'b1;
`endif

    if (ren_dly_q) begin
      if (state_q == DUMMY) cur_d = bram_dout;
      else                  nxt_d = bram_dout;
    end

    if (cs_lvl) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall && armed_q) begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: if (sck_rise) begin
          cmd_hi_d = sd;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == 8'(CMD_NIBBLES - 1)) begin
            cnt_d   = '0;
            state_d = IGNORE;
            if ({cmd_hi_q, sd} == CMD_QREAD) state_d = ADDR;
`ifdef QSPI_EMU_WRITE_EN
            is_wr_d = ({cmd_hi_q, sd} == CMD_QWRITE);
            if ({cmd_hi_q, sd} == CMD_QWRITE) state_d = ADDR;
`endif
          end
        end
        ADDR: if (sck_rise) begin
          addr_d = {addr_q[19:0], sd};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'(ADDR_NIBBLES - 1)) begin
            baddr_d  = addr_d[ADDR_WIDTH-1:0];
            cnt_d    = '0;
            nib_hi_d = 1'b1;
`ifdef QSPI_EMU_WRITE_EN
            if (is_wr_q) state_d = WR_DATA;
            else
`endif
            begin
              ren_d   = 1'b1;
              state_d = DUMMY;
            end
          end
        end
        DUMMY: if (sck_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(DUMMY_CYCLES - 1)) state_d = RD_DATA;
        end
        RD_DATA: begin
          if (sck_fall) begin
            dout_d = nib_hi_q ? cur_q[7:4] : cur_q[3:0];
            oe_d   = 1'b1;
          end
          // High-nibble rise prefetches the next byte; low-nibble rise swaps it in.
          if (sck_rise) begin
            nib_hi_d = ~nib_hi_q;
            if (nib_hi_q) begin
              baddr_d = baddr_q + 1'b1;
              ren_d   = 1'b1;
            end else begin
              cur_d = nxt_q;
            end
          end
        end
`ifdef QSPI_EMU_WRITE_EN
        WR_DATA: if (sck_rise) begin
          nib_hi_d = ~nib_hi_q;
          if (nib_hi_q) begin
            wr_hi_d = sd;
          end else begin
            din_d = {wr_hi_q, sd};
            wen_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_sync_q  <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_hi_q  <= '0;
      addr_q    <= '0;
      nib_hi_q  <= 1'b0;
      cur_q     <= '0;
      nxt_q     <= '0;
      ren_dly_q <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      baddr_q   <= '0;
      ren_q     <= 1'b0;
    end else begin
      d_sync_q  <= {d_sync_q[0], spi_d_in};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_hi_q  <= cmd_hi_d;
      addr_q    <= addr_d;
      nib_hi_q  <= nib_hi_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      ren_dly_q <= ren_q;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      baddr_q   <= baddr_d;
      ren_q     <= ren_d;
    end
  end

`ifdef QSPI_EMU_WRITE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q <= 1'b0;
      wr_hi_q <= '0;
      din_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      is_wr_q <= is_wr_d;
      wr_hi_q <= wr_hi_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
    end
  end
  assign bram_din = din_q;
  assign bram_wen = wen_q;
`else
  assign bram_din = '0;
  assign bram_wen = 1'b0;
`endif

  assign spi_d_out = dout_q;
  assign spi_d_oe  = oe_q;
  assign bram_addr = baddr_q;
  assign bram_ren  = ren_q;

endmodule
